// File: rtl/and_unit_pkg.sv
// Shared types and constants for the round-robin AND arbiter.
// The optional grant counter is enabled by AND_UNIT_ARBITER_STATS_EN in and_unit_arbiter.
package and_unit_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;
    localparam int STATS_W   = 16;

    // Increment modulo n; used for the round-robin pointer advance.
    function automatic int wrap_inc(input int v, input int n);
        if (v >= n - 1) begin
            return 0;
        end else begin
            return v + 1;
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: first valid request at or after ptr,
// searching upward modulo NREQ. Returns a one-hot grant and its index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    logic [IDW:0] idx_s;
    logic         found_s;

    // Walk the NREQ candidates starting at ptr and latch the first valid one.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        idx_s     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = {1'b0, ptr} + (IDW+1)'(k);
            if (idx_s >= (IDW+1)'(NREQ)) begin
                idx_s = idx_s - (IDW+1)'(NREQ);
            end else begin
                idx_s = idx_s;
            end
            if (en && !found_s && req_valid[idx_s[IDW-1:0]]) begin
                grant[idx_s[IDW-1:0]] = 1'b1;
                grant_idx             = idx_s[IDW-1:0];
                found_s               = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        grant_any = found_s;
    end

endmodule

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one registered a&b datapath among NREQ requesters.
// Define AND_UNIT_ARBITER_STATS_EN to add the saturating grant_count output.
module and_unit_arbiter
    import and_unit_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
`ifdef AND_UNIT_ARBITER_STATS_EN
    output logic [STATS_W-1:0]    grant_count,
`endif
    input  logic                  rsp_ready
);

    slot_state_t      state_r;
    slot_state_t      state_nxt_s;
    logic [IDW-1:0]   ptr_r;
    logic [WIDTH-1:0] data_r;
    logic [IDW-1:0]   id_r;

    logic             free_s;
    logic             en_s;
    logic [NREQ-1:0]  grant_s;
    logic [IDW-1:0]   grant_idx_s;
    logic             grant_any_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;

    // Gating with reset_n keeps req_ready low while reset is held.
    assign free_s = (state_r == EMPTY) | rsp_ready;
    assign en_s   = free_s & reset_n;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_r),
        .en        (en_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    assign req_ready = grant_s;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i]) begin
                sel_a_s = req_a[i*WIDTH +: WIDTH];
                sel_b_s = req_b[i*WIDTH +: WIDTH];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    // Slot state and round-robin pointer registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= EMPTY;
            ptr_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_any_s) begin
                ptr_r <= IDW'(wrap_inc(int'(grant_idx_s), NREQ));
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    // Slot next-state: a grant always fills; a drain without a grant empties.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (grant_any_s) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (rsp_ready && !grant_any_s) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: state_nxt_s = EMPTY;
        endcase
    end

    // Slot output decode.
    always_comb begin
        rsp_valid = 1'b0;
        case (state_r)
            FULL:    rsp_valid = 1'b1;
            EMPTY:   rsp_valid = 1'b0;
            default: rsp_valid = 1'b0;
        endcase
    end

    // Result register loads only on a grant so a stalled response stays stable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= '0;
            id_r   <= '0;
        end else if (grant_any_s) begin
            data_r <= sel_a_s & sel_b_s;
            id_r   <= grant_idx_s;
        end else begin
            data_r <= data_r;
            id_r   <= id_r;
        end
    end

    assign rsp_data = data_r;
    assign rsp_id   = id_r;

`ifdef AND_UNIT_ARBITER_STATS_EN
    logic [STATS_W-1:0] count_r;

    // Saturating grant counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (grant_any_s && (count_r != {STATS_W{1'b1}})) begin
            count_r <= count_r + STATS_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign grant_count = count_r;
`endif

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Self-checking bench for and_unit_arbiter against a cycle-level queue-free reference model.
// Define AND_UNIT_ARBITER_STATS_EN to also exercise grant_count saturation.
module tb_and_unit_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clock;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_ready;
`ifdef AND_UNIT_ARBITER_STATS_EN
    logic [15:0]           grant_count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    int        m_ptr;
    bit        m_valid;
    bit [7:0]  m_data;
    int        m_id;
    longint    m_cnt;

    and_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
`ifdef AND_UNIT_ARBITER_STATS_EN
        .grant_count (grant_count),
`endif
        .rsp_ready   (rsp_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int exp_grant();
        if (!reset_n) return -1;
        if (m_valid && !rsp_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int g;
        g = exp_grant();
        if (g < 0) return '0;
        return NREQ'(1) << g;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_data = 8'h00; m_id = 0; m_cnt = 0;
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic model_step();
        int g;
        g = exp_grant();
        if (g >= 0) begin
            m_valid = 1;
            m_data  = req_a[g*WIDTH +: WIDTH] & req_b[g*WIDTH +: WIDTH];
            m_id    = g;
            m_ptr   = (g + 1) % NREQ;
            m_cnt++;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic rand_operands();
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1; rand_operands();
        model_reset();
        repeat (3) @(negedge clock);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        reset_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
        model_step();
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_first_rsp got=%b/%0d exp=1/0", rsp_valid, rsp_id); end
    endtask

    task automatic test_single();
        // Drain the slot first
        req_valid = 4'b0000; rsp_ready = 1'b1;
        #1; model_step(); @(negedge clock);
        req_valid = 4'b0100; req_a = '0; req_b = '0;
        req_a[2*WIDTH +: WIDTH] = 8'hF0; req_b[2*WIDTH +: WIDTH] = 8'h3C;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        model_step(); @(negedge clock);
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h30 || rsp_id !== 2'd2) begin
            errors++; $display("FAIL single_rsp got=%b/%h/%0d exp=1/30/2", rsp_valid, rsp_data, rsp_id); end
        checks++; if (int'(dut.ptr_r) !== 3) begin errors++; $display("FAIL single_ptr got=%0d exp=3", dut.ptr_r); end
        // Idle cycle: ptr must hold
        #1; model_step(); @(negedge clock);
        checks++; if (rsp_valid !== 1'b0 || int'(dut.ptr_r) !== 3) begin
            errors++; $display("FAIL idle_hold got=%b/%0d exp=0/3", rsp_valid, dut.ptr_r); end
    endtask

    task automatic test_round_robin();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        // Only requester 3 valid: wraps ptr from 3 to 0
        req_valid = 4'b1000; rsp_ready = 1'b1; rand_operands();
        #1; model_step(); @(negedge clock);
        checks++; if (int'(dut.ptr_r) !== 0) begin errors++; $display("FAIL wrap_ptr got=%0d exp=0", dut.ptr_r); end
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            rand_operands();
            #1;
            checks++; if (req_ready !== (4'b0001 << exp_seq[c])) begin
                errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, req_ready, 4'b0001 << exp_seq[c]); end
            model_step(); @(negedge clock);
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== m_data || int'(rsp_id) !== m_id) begin
                errors++; $display("FAIL rr_rsp[%0d] got=%b/%h/%0d exp=1/%h/%0d", c, rsp_valid, rsp_data, rsp_id, m_data, m_id); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held_d;
        logic [1:0] held_id;
        req_valid = 4'b1111; rsp_ready = 1'b0;
        held_d = rsp_data; held_id = rsp_id;
        for (int c = 0; c < 3; c++) begin
            rand_operands();
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, req_ready); end
            model_step(); @(negedge clock);
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== held_d || rsp_id !== held_id) begin
                errors++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d exp=1/%h/%0d", c, rsp_valid, rsp_data, rsp_id, held_d, held_id); end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== exp_ready() || req_ready === 4'b0000) begin
            errors++; $display("FAIL bp_release_grant got=%b exp=%b", req_ready, exp_ready()); end
        model_step(); @(negedge clock);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== m_data || int'(rsp_id) !== m_id) begin
            errors++; $display("FAIL bp_release_rsp got=%b/%h/%0d exp=1/%h/%0d", rsp_valid, rsp_data, rsp_id, m_data, m_id); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_operands();
            #1;
            checks++; if (req_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, req_ready, exp_ready()); end
            model_step(); @(negedge clock);
            checks++; if (rsp_valid !== m_valid || (m_valid && (rsp_data !== m_data || int'(rsp_id) !== m_id))) begin
                errors++; $display("FAIL rand_rsp[%0d] got=%b/%h/%0d exp=%b/%h/%0d", c, rsp_valid, rsp_data, rsp_id, m_valid, m_data, m_id); end
        end
    endtask

    task automatic test_reset_midflight();
        req_valid = 4'b0010; rsp_ready = 1'b0; rand_operands();
        #1; model_step(); @(negedge clock);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_full got=%b exp=1", rsp_valid); end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_async got=%b/%b exp=0/0000", rsp_valid, req_ready); end
        checks++; if (int'(dut.ptr_r) !== 0 || rsp_data !== 8'h00) begin
            errors++; $display("FAIL mid_ptr got=%0d/%h exp=0/00", dut.ptr_r, rsp_data); end
        @(negedge clock);
        reset_n = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_regrant got=%b exp=0010", req_ready); end
        model_step(); @(negedge clock);
    endtask

`ifdef AND_UNIT_ARBITER_STATS_EN
    task automatic test_stats();
        longint exp_cnt;
        req_valid = 4'b1111; rsp_ready = 1'b1;
        exp_cnt = (m_cnt > 65535) ? 65535 : m_cnt;
        checks++; if (longint'(grant_count) !== exp_cnt) begin
            errors++; $display("FAIL stats_start got=%0d exp=%0d", grant_count, exp_cnt); end
        for (int c = 0; c < 70000; c++) begin
            model_step(); @(negedge clock);
        end
        exp_cnt = (m_cnt > 65535) ? 65535 : m_cnt;
        checks++; if (longint'(grant_count) !== exp_cnt || grant_count !== 16'hFFFF) begin
            errors++; $display("FAIL stats_sat got=%0d exp=%0d", grant_count, exp_cnt); end
    endtask
`endif

    initial begin
        reset_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        model_reset();
        @(negedge clock);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_random();
        test_reset_midflight();
`ifdef AND_UNIT_ARBITER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
